// File: rtl/counter_pkg.sv
// Shared constants and parameter legality check for the N-bit up/down counter.
package counter_pkg;

  localparam int MODE_WRAP = 1;
  localparam int MODE_SAT  = 0;
  localparam int EDGE_ON   = 1;
  localparam int EDGE_OFF  = 0;

  // True when the parameter set describes a buildable counter.
  function automatic bit params_legal(input int width, input int maxValue,
                                      input int startValue, input int wrap,
                                      input int edgeMode);
    longint limit;
    limit = (width >= 62) ? 64'h3FFF_FFFF_FFFF_FFFF : ((64'sd1 <<< width) - 1);
    return (width >= 1) && (maxValue >= 1) && (longint'(maxValue) <= limit) &&
           (startValue >= 0) && (startValue <= maxValue) &&
           (wrap == MODE_WRAP || wrap == MODE_SAT) &&
           (edgeMode == EDGE_ON || edgeMode == EDGE_OFF);
  endfunction

endpackage

// File: rtl/counter_nbit_updown_if.sv
// Request/status bundle between request sources, the counter and display logic.
interface counter_nbit_updown_if #(parameter int WIDTH = 4);

  logic             Increase;
  logic             Decrease;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic [WIDTH-1:0] Count;
  logic             AtMax;
  logic             AtZero;
  logic             Overflow;
  logic             Underflow;

  modport master (output Increase, Decrease, Load, LoadValue,
                  input  Count, AtMax, AtZero, Overflow, Underflow);

  modport slave  (input  Increase, Decrease, Load, LoadValue,
                  output Count, AtMax, AtZero, Overflow, Underflow);

endinterface

// File: rtl/edge_qualify.sv
// Turns a request line into a one-cycle step (rising-edge mode) or passes it
// straight through (level mode).
module edge_qualify
  import counter_pkg::*;
#(
  parameter int EDGE_MODE = EDGE_ON
) (
  input  logic Clock,
  input  logic Reset,
  input  logic request,
  output logic step
);

  logic requestD;

  // Cleared on reset so a request still high at release reads as a fresh edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) requestD <= 1'b0;
    else       requestD <= request;
  end

  assign step = (EDGE_MODE == EDGE_ON) ? (request & ~requestD) : request;

endmodule

// File: rtl/counter_nbit_updown.sv
// Parametrised up/down counter with load, wrap/saturate limits and
// registered overflow/underflow pulses.
module counter_nbit_updown
  import counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MAX_VALUE   = 2**WIDTH - 1,
  parameter int START_VALUE = 0,
  parameter int WRAP        = MODE_WRAP,
  parameter int EDGE_MODE   = EDGE_ON
) (
  input logic                  Clock,
  input logic                  Reset,
  counter_nbit_updown_if.slave bus
);

  if (!params_legal(WIDTH, MAX_VALUE, START_VALUE, WRAP, EDGE_MODE)) begin : gBadParams
    $error("counter_nbit_updown: illegal WIDTH/MAX_VALUE/START_VALUE/WRAP/EDGE_MODE");
  end

  localparam logic [WIDTH-1:0] MAXV   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] STARTV = WIDTH'(START_VALUE);

  logic             up;
  logic             dn;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] countNext;
  logic             overflow;
  logic             overflowNext;
  logic             underflow;
  logic             underflowNext;

  edge_qualify #(.EDGE_MODE(EDGE_MODE)) uIncQual (
    .Clock   (Clock),
    .Reset   (Reset),
    .request (bus.Increase),
    .step    (up)
  );

  edge_qualify #(.EDGE_MODE(EDGE_MODE)) uDecQual (
    .Clock   (Clock),
    .Reset   (Reset),
    .request (bus.Decrease),
    .step    (dn)
  );

  // Limits are tested before stepping so no value ever needs more than WIDTH bits.
  always_comb begin
    countNext     = count;
    overflowNext  = 1'b0;
    underflowNext = 1'b0;
    if (bus.Load) begin
      countNext = (bus.LoadValue > MAXV) ? MAXV : bus.LoadValue;
    end else if (up && dn) begin
      countNext = count;
    end else if (up) begin
      if (count == MAXV) begin
        overflowNext = 1'b1;
        if (WRAP == MODE_WRAP) countNext = '0;
      end else begin
        countNext = count + 1'b1;
      end
    end else if (dn) begin
      if (count == '0) begin
        underflowNext = 1'b1;
        if (WRAP == MODE_WRAP) countNext = MAXV;
      end else begin
        countNext = count - 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count     <= STARTV;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= countNext;
      overflow  <= overflowNext;
      underflow <= underflowNext;
    end
  end

  assign bus.Count     = count;
  assign bus.AtMax     = (count == MAXV);
  assign bus.AtZero    = (count == '0);
  assign bus.Overflow  = overflow;
  assign bus.Underflow = underflow;

endmodule

// File: tb/tb_counter_nbit_updown.sv
// Scoreboard bench: three counter configurations driven with directed vectors.
module tb_counter_nbit_updown;
  import counter_pkg::*;

  typedef struct {
    int         dut;
    logic [3:0] cnt;
    logic       ov;
    logic       un;
    string      name;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  always #5 Clock = ~Clock;

  counter_nbit_updown_if #(.WIDTH(4)) busA ();
  counter_nbit_updown_if #(.WIDTH(4)) busB ();
  counter_nbit_updown_if #(.WIDTH(4)) busC ();

  counter_nbit_updown #(.WIDTH(4), .MAX_VALUE(9), .START_VALUE(3),
                        .WRAP(MODE_WRAP), .EDGE_MODE(EDGE_ON))
    dutA (.Clock(Clock), .Reset(Reset), .bus(busA));

  counter_nbit_updown #(.WIDTH(4), .MAX_VALUE(15), .START_VALUE(0),
                        .WRAP(MODE_SAT), .EDGE_MODE(EDGE_ON))
    dutB (.Clock(Clock), .Reset(Reset), .bus(busB));

  counter_nbit_updown #(.WIDTH(4), .MAX_VALUE(15), .START_VALUE(2),
                        .WRAP(MODE_WRAP), .EDGE_MODE(EDGE_OFF))
    dutC (.Clock(Clock), .Reset(Reset), .bus(busC));

  task automatic checkOutput(input int d, input string name, input logic [3:0] cnt,
                             input logic ov, input logic un);
    logic [3:0] aCnt;
    logic       aMax, aZero, aOv, aUn, eMax, eZero;
    case (d)
      0:       begin aCnt = busA.Count; aMax = busA.AtMax; aZero = busA.AtZero;
                     aOv = busA.Overflow; aUn = busA.Underflow; eMax = (cnt == 4'd9); end
      1:       begin aCnt = busB.Count; aMax = busB.AtMax; aZero = busB.AtZero;
                     aOv = busB.Overflow; aUn = busB.Underflow; eMax = (cnt == 4'd15); end
      default: begin aCnt = busC.Count; aMax = busC.AtMax; aZero = busC.AtZero;
                     aOv = busC.Overflow; aUn = busC.Underflow; eMax = (cnt == 4'd15); end
    endcase
    eZero = (cnt == 4'd0);
    checks++;
    if (aCnt !== cnt || aMax !== eMax || aZero !== eZero || aOv !== ov || aUn !== un) begin
      errors++;
      $display("[TB] FAIL %s (dut %0d): got cnt=%0d max=%b zero=%b ov=%b un=%b, want cnt=%0d max=%b zero=%b ov=%b un=%b",
               name, d, aCnt, aMax, aZero, aOv, aUn, cnt, eMax, eZero, ov, un);
    end
  endtask

  // Drive one cycle of inputs on the selected counter (others idle) and queue the
  // state expected after the next rising edge.
  task automatic applyStimulus(input int d, input logic rst, input logic inc, input logic dec,
                               input logic ld, input logic [3:0] lv, input logic [3:0] cnt,
                               input logic ov, input logic un, input string name);
    exp_t e;
    @(negedge Clock);
    Reset = rst;
    busA.Increase = 1'b0; busA.Decrease = 1'b0; busA.Load = 1'b0; busA.LoadValue = '0;
    busB.Increase = 1'b0; busB.Decrease = 1'b0; busB.Load = 1'b0; busB.LoadValue = '0;
    busC.Increase = 1'b0; busC.Decrease = 1'b0; busC.Load = 1'b0; busC.LoadValue = '0;
    case (d)
      0:       begin busA.Increase = inc; busA.Decrease = dec; busA.Load = ld; busA.LoadValue = lv; end
      1:       begin busB.Increase = inc; busB.Decrease = dec; busB.Load = ld; busB.LoadValue = lv; end
      default: begin busC.Increase = inc; busC.Decrease = dec; busC.Load = ld; busC.LoadValue = lv; end
    endcase
    e.dut = d; e.cnt = cnt; e.ov = ov; e.un = un; e.name = name;
    expQ.push_back(e);
  endtask

  // Monitor: each registered update is compared just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.dut, e.name, e.cnt, e.ov, e.un);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wait_cycles;
    Reset = 1'b1;
    busA.Increase = 1'b0; busA.Decrease = 1'b0; busA.Load = 1'b0; busA.LoadValue = '0;
    busB.Increase = 1'b0; busB.Decrease = 1'b0; busB.Load = 1'b0; busB.LoadValue = '0;
    busC.Increase = 1'b0; busC.Decrease = 1'b0; busC.Load = 1'b0; busC.LoadValue = '0;
    #1;
    checkOutput(0, "resetImmediateA", 4'd3, 1'b0, 1'b0);
    checkOutput(2, "resetImmediateC", 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 4'd3, 0, 0, "resetHoldA");

    // Counter B: rising-edge qualification, then saturation at both limits.
    applyStimulus(1, 0, 1, 0, 0, 0,  4'd1,  0, 0, "edgeFirst");
    applyStimulus(1, 0, 1, 0, 0, 0,  4'd1,  0, 0, "edgeHeld1");
    applyStimulus(1, 0, 1, 0, 0, 0,  4'd1,  0, 0, "edgeHeld2");
    applyStimulus(1, 0, 1, 0, 0, 0,  4'd1,  0, 0, "edgeHeld3");
    applyStimulus(1, 0, 0, 0, 0, 0,  4'd1,  0, 0, "edgeLow1");
    applyStimulus(1, 0, 0, 0, 0, 0,  4'd1,  0, 0, "edgeLow2");
    applyStimulus(1, 0, 1, 0, 0, 0,  4'd2,  0, 0, "edgeSecond");
    applyStimulus(1, 0, 0, 0, 0, 0,  4'd2,  0, 0, "edgeIdle");
    applyStimulus(1, 0, 0, 0, 1, 15, 4'd15, 0, 0, "satLoad15");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 0, 4'd15, 1, 0, "satOverflow");
      applyStimulus(1, 0, 0, 0, 0, 0, 4'd15, 0, 0, "satOverflowGap");
    end
    applyStimulus(1, 0, 0, 1, 0, 0,  4'd14, 0, 0, "satDownFromMax");
    applyStimulus(1, 0, 0, 0, 1, 0,  4'd0,  0, 0, "satLoad0");
    applyStimulus(1, 0, 0, 1, 0, 0,  4'd0,  0, 1, "satUnderflow");
    applyStimulus(1, 0, 0, 0, 0, 0,  4'd0,  0, 0, "satUnderflowGap");

    // Counter A: wrap at MAX_VALUE=9, load clamp, coincident requests.
    applyStimulus(0, 0, 0, 0, 1, 9,  4'd9, 0, 0, "wrapLoad9");
    applyStimulus(0, 0, 1, 0, 0, 0,  4'd0, 1, 0, "wrapOverflow");
    applyStimulus(0, 0, 0, 0, 0, 0,  4'd0, 0, 0, "wrapOverflowEnd");
    applyStimulus(0, 0, 0, 1, 0, 0,  4'd9, 0, 1, "wrapUnderflow");
    applyStimulus(0, 0, 0, 0, 0, 0,  4'd9, 0, 0, "wrapUnderflowEnd");
    applyStimulus(0, 0, 1, 0, 1, 12, 4'd9, 0, 0, "loadClampWithEdge");
    applyStimulus(0, 0, 1, 0, 0, 0,  4'd9, 0, 0, "loadEdgeNotReplayed1");
    applyStimulus(0, 0, 1, 0, 0, 0,  4'd9, 0, 0, "loadEdgeNotReplayed2");
    applyStimulus(0, 0, 0, 0, 0, 0,  4'd9, 0, 0, "loadIdle");
    applyStimulus(0, 0, 0, 0, 1, 5,  4'd5, 0, 0, "load5");
    applyStimulus(0, 0, 1, 1, 0, 0,  4'd5, 0, 0, "bothRise");
    applyStimulus(0, 0, 1, 1, 0, 0,  4'd5, 0, 0, "bothHeld");
    applyStimulus(0, 0, 0, 0, 0, 0,  4'd5, 0, 0, "bothLow");
    applyStimulus(0, 0, 0, 1, 0, 0,  4'd4, 0, 0, "downStep");
    applyStimulus(0, 0, 0, 0, 0, 0,  4'd4, 0, 0, "downIdle");
    applyStimulus(0, 0, 1, 0, 0, 0,  4'd5, 0, 0, "upStep");

    // Counter C: level mode, async reset in the middle of an up-run.
    applyStimulus(2, 0, 1, 0, 0, 0, 4'd3, 0, 0, "levelUp1");
    applyStimulus(2, 0, 1, 0, 0, 0, 4'd4, 0, 0, "levelUp2");
    applyStimulus(2, 0, 1, 0, 0, 0, 4'd5, 0, 0, "levelUp3");
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput(2, "resetMidRun", 4'd2, 1'b0, 1'b0);
    applyStimulus(2, 1, 1, 0, 0, 0, 4'd2, 0, 0, "resetHoldC1");
    applyStimulus(2, 1, 1, 0, 0, 0, 4'd2, 0, 0, "resetHoldC2");
    applyStimulus(2, 0, 1, 0, 0, 0, 4'd3, 0, 0, "releaseFirstStep");
    applyStimulus(2, 0, 1, 0, 0, 0, 4'd4, 0, 0, "releaseSecondStep");
    applyStimulus(2, 0, 0, 0, 0, 0, 4'd4, 0, 0, "levelIdle");
    applyStimulus(2, 0, 0, 1, 0, 0, 4'd3, 0, 0, "levelDown1");
    applyStimulus(2, 0, 0, 1, 0, 0, 4'd2, 0, 0, "levelDown2");

    wait_cycles = 0;
    while (expQ.size() > 0 && wait_cycles < 10) begin
      @(posedge Clock);
      wait_cycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainQueue: got %0d pending entries, want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_nbit_updown.md
# counter_nbit_updown

Parametrised N-bit up/down counter, successor to the 1-bit start-at-0 counter. It adds configurable width, modulus, reset value, wrap or saturate at the limits, synchronous load, and optional rising-edge qualification of the request inputs. It sits between debounced request sources (sensor or push-button pulses) and display/decode logic, and exposes terminal-count flags plus overflow and underflow pulses.

## Interface
- WIDTH, 4: counter width in bits; legal range ≥1.
- MAX_VALUE, 2**WIDTH-1: upper count limit; legal range 1 ≤ MAX_VALUE ≤ 2**WIDTH-1.
- START_VALUE, 0: value loaded by Reset; legal range ≤ MAX_VALUE.
- WRAP, 1: 1 = modulo (MAX_VALUE+1) wrap; 0 = saturate at 0 and MAX_VALUE.
- EDGE_MODE, 1: 1 = one step per rising edge of a request; 0 = one step per cycle while the request is high.
- Clock  in  1  single system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Increase  in  1  count-up request.
- Decrease  in  1  count-down request.
- Load  in  1  synchronous load strobe.
- LoadValue  in  WIDTH  value applied on Load.
- Count  out  WIDTH  current count, registered.
- AtMax  out  1  high when Count == MAX_VALUE.
- AtZero  out  1  high when Count == 0.
- Overflow  out  1  one-cycle pulse when an up-step is taken at MAX_VALUE.
- Underflow  out  1  one-cycle pulse when a down-step is taken at 0.

## Operation
- Qualified requests:
  - EDGE_MODE=1: up = Increase & ~Increase_d, where Increase_d is the previous-cycle sample. Decrease is qualified the same way.
  - EDGE_MODE=0: up = Increase, dn = Decrease.
- The history registers Increase_d and Decrease_d update every cycle, whatever Load is doing.
- Per-cycle priority, highest first:
  - Load: Count ← min(LoadValue, MAX_VALUE). No pulses.
  - up & dn: no change, no pulses.
  - up:
    - Count < MAX_VALUE: Count+1.
    - Count == MAX_VALUE with WRAP=1: Count ← 0 and Overflow pulses.
    - Count == MAX_VALUE with WRAP=0: Count holds and Overflow pulses.
  - dn:
    - Count > 0: Count-1.
    - Count == 0 with WRAP=1: Count ← MAX_VALUE and Underflow pulses.
    - Count == 0 with WRAP=0: Count holds and Underflow pulses.
  - Otherwise: hold.
- Arithmetic is unsigned at WIDTH bits. No intermediate value may exceed WIDTH bits; compare against MAX_VALUE before incrementing.
- Reset (async) forces:
  - Count = START_VALUE.
  - Overflow = Underflow = 0.
  - Increase_d = Decrease_d = 0.
  - AtMax and AtZero follow from START_VALUE.
- Reset asserted mid-operation: takes effect immediately, with no partial step. A request that is still high when Reset deasserts counts as a rising edge on the first Clock edge after release (EDGE_MODE=1).

## Timing
- Latency: a request sampled at edge k changes Count immediately after edge k, i.e. one register stage.
- Overflow and Underflow are registered. Each is high for exactly the one cycle following the edge at which its step was taken, aligned with the Count update.
- AtMax and AtZero are a combinational decode of the Count register. They add no latency and are glitch-free relative to Clock.
- EDGE_MODE=1: a request held high for N cycles produces exactly one step.
- EDGE_MODE=0: a request held high for N cycles produces N steps.
- A rising edge coincident with Load is consumed by Load and is not replayed.

## Structure
- Shared package counter_pkg:
  - Mode constants MODE_WRAP=1, MODE_SAT=0, EDGE_ON=1, EDGE_OFF=0.
  - Parameter legality check macro or function, used for elaboration-time assertions.
- One sub-module, edge_qualify: per-input history register plus the EDGE_MODE mux. It is instantiated twice, once for Increase and once for Decrease, and uses the same Clock/Reset.
- The top level holds the count register, the priority/next-state logic, and the pulse registers.

## Test plan
- Reset with START_VALUE=3, WIDTH=4: Count=3, AtZero=0, AtMax=0 immediately on Reset, before any Clock edge. Hold Reset 3 cycles: no change.
- EDGE_MODE=1, Increase high for 4 cycles, then low for 2, then high for 1: Count 0→1→2, exactly two steps.
- WRAP=1, MAX_VALUE=9, Count=9, one Increase edge: Count=0, Overflow high for 1 cycle. Then one Decrease edge: Count=9, Underflow high for 1 cycle.
- WRAP=0, MAX_VALUE=15, Count=15, three Increase pulses: Count stays 15, AtMax=1, three separate Overflow pulses.
- Load with LoadValue=12 and MAX_VALUE=9, Increase edge in the same cycle: Count=9, no Overflow. Increase held high afterwards gives no further step.
- Increase and Decrease rise together at Count=5: Count stays 5, no pulses. Assert Reset mid-way through an EDGE_MODE=0 up-run and release it with Increase high: Count=START_VALUE, then increments from the first edge after release.
